data_memory_responder: RTL

Data-memory responder for the RV64 multicycle datapath. Accepts the single-cycle `write_mem` / `load_data_memory` strobes issued by the control-unit FSMs. Performs byte/half/word/doubleword loads and stores on an internal 64-bit-wide RAM. Returns sign- or zero-extended load data on `rdata`, with a `done` pulse back to the control unit.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/data_memory_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 data-memory responder: funct3 access codes,
// FSM state encoding and access-size helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD    = 2'd1;
  localparam logic [1:0] ST_LDRET = 2'd2;
  localparam logic [1:0] ST_MERGE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RD    = ST_RD,
    LDRET = ST_LDRET,
    MERGE = ST_MERGE
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

  // log2 of the access size in bytes; funct3 3'b111 lands on a doubleword
  function automatic logic [1:0] size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  // Byte-offset bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [2:0] funct3);
    logic [2:0] mask;
    unique case (size_log2(funct3))
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a load value from a RAM word
// and merges narrow store data into a RAM word (little-endian).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  output logic [63:0] load_value,
  output logic [63:0] merged
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] size_mask;

  assign shamt = {offset, 3'b000};
  assign lane  = word >> shamt;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    unique case (size_log2(funct3))
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  always_comb begin
    load_value = lane;
    unique case (funct3)
      F3_B:    load_value = {{56{lane[7]}},  lane[7:0]};
      F3_H:    load_value = {{48{lane[15]}}, lane[15:0]};
      F3_W:    load_value = {{32{lane[31]}}, lane[31:0]};
      F3_BU:   load_value = {56'd0, lane[7:0]};
      F3_HU:   load_value = {48'd0, lane[15:0]};
      F3_WU:   load_value = {32'd0, lane[31:0]};
      default: load_value = lane;
    endcase
  end

  // A doubleword store has an all-ones mask, so the old word drops out entirely
  assign merged = (word & ~(size_mask << shamt)) | ((wdata & size_mask) << shamt);

endmodule

// File: rtl/data_memory_responder.sv
// RV64 multicycle data-memory responder: byte..doubleword loads/stores on an
// internal 64-bit RAM. Optional misalignment trap via `MEM_MISALIGN_TRAP_EN.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        write_mem,
  input  logic        load_data_memory,
  output logic [63:0] rdata,
  output logic        done,
  output logic        busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  state_t      state, next_state;
  op_t         op_q;
  logic [AW-1:0] idx_q;
  logic [2:0]  off_q;
  logic [2:0]  f3_q;
  logic [63:0] wdata_q;
  logic [63:0] ram_q;
  logic [63:0] load_value;
  logic [63:0] merged;
  logic        accept;
  logic        mem_we;
  logic        rdata_we;
  logic        finish;
  logic        mis_hit;

  logic [63:0] mem [DEPTH];

  // Bits above the RAM span are deliberately ignored so addresses wrap
  logic unused_addr;
  assign unused_addr = ^addr[63:AW+3];

  assign accept = (state == IDLE) && (write_mem || load_data_memory);
  assign busy   = (state != IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign mis_hit = mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      if (accept) mis_q <= |(addr[2:0] & align_mask(funct3));
      if (finish && mis_q) misaligned <= 1'b1;
    end
  end
`else
  assign mis_hit = 1'b0;
`endif

  mem_lane_align u_lane (
    .word       (ram_q),
    .offset     (off_q),
    .funct3     (f3_q),
    .wdata      (wdata_q),
    .load_value (load_value),
    .merged     (merged)
  );

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    rdata_we   = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_mem)             next_state = (size_log2(funct3) == 2'd3) ? MERGE : RD;
        else if (load_data_memory) next_state = RD;
      end
      RD:    next_state = (op_q == OP_STORE) ? MERGE : LDRET;
      LDRET: begin
        next_state = IDLE;
        finish     = 1'b1;
        rdata_we   = ~mis_hit;
      end
      MERGE: begin
        next_state = IDLE;
        finish     = 1'b1;
        mem_we     = ~mis_hit;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_LOAD;
      idx_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= finish;
      if (rdata_we) rdata <= load_value;
      if (accept) begin
        op_q    <= write_mem ? OP_STORE : OP_LOAD;
        idx_q   <= addr[AW+2:3];
        off_q   <= addr[2:0] & ~align_mask(funct3);
        f3_q    <= funct3;
        wdata_q <= wdata;
      end
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= merged;
    ram_q <= mem[idx_q];
  end

endmodule
